// File: rtl/rca_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package rca_seq_ctrl_pkg;

  // Width of the single time-multiplexed adder slice
  localparam int unsigned SliceW = 4;

  // Controller states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/add4_slice.sv
// Combinational adder slice; also reports signed overflow of its MSB.
module add4_slice
  import rca_seq_ctrl_pkg::*;
(
  input  logic [SliceW-1:0] a,
  input  logic [SliceW-1:0] b,
  input  logic              cin,
  output logic [SliceW-1:0] s,
  output logic              cout,
  output logic              ovf
);

  // Low bits plus carry into the MSB, kept separate so ovf can see that carry
  logic [SliceW-1:0] low;
  logic [1:0]        high;

  // Split the add at the MSB to expose carry-in and carry-out of the top bit
  always_comb begin
    low  = {1'b0, a[SliceW-2:0]} + {1'b0, b[SliceW-2:0]} + {{(SliceW-1){1'b0}}, cin};
    high = {1'b0, a[SliceW-1]} + {1'b0, b[SliceW-1]} + {1'b0, low[SliceW-1]};
    s    = {high[0], low[SliceW-2:0]};
    cout = high[1];
    ovf  = low[SliceW-1] ^ high[1];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide add/subtract computed one nibble per clock through a single adder slice.
module rca_seq_ctrl
  import rca_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             O_ovf
);

  localparam int unsigned NSLICE = WIDTH / SliceW;
  localparam int unsigned IdxW   = $clog2(NSLICE);
  localparam int unsigned LsbW   = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;

  logic [LsbW-1:0]   lsb;
  logic [SliceW-1:0] slice_s;
  logic              slice_cout;
  logic              slice_ovf;
  logic              last_slice;

  assign lsb        = LsbW'(idx_q) * LsbW'(SliceW);
  assign last_slice = (idx_q == IdxW'(NSLICE - 1));

  add4_slice u_slice (
    .a    (a_q[lsb +: SliceW]),
    .b    (b_q[lsb +: SliceW]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .ovf  (slice_ovf)
  );

  // Next-state: operand capture in idle, one slice per cycle in run
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = A;
          // Subtract as A + ~B + 1: invert B here, the +1 enters as initial carry
          b_d     = B ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          s_d     = '0;
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        s_d[lsb +: SliceW] = slice_s;
        carry_d            = slice_cout;
        if (last_slice) begin
          idx_d   = '0;
          c_out_d = slice_cout;
          ovf_d   = slice_ovf;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign S     = s_q;
  assign C_out = c_out_q;
  assign O_ovf = ovf_q;

endmodule
